// File: rtl/rotation_decoder_if.sv
// Handshake and result bundle for rotation_decoder.
// The decoder connects through the slave modport and the requester through the master modport.
interface rotation_decoder_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned AW = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] data_ref;
  logic [WIDTH-1:0] data_rot;
  logic             busy;
  logic             done;
  logic             found;
  logic             direction;
  logic [AW-1:0]    shift_amt;

  modport master (
    output start, data_ref, data_rot,
    input  busy, done, found, direction, shift_amt
  );

  modport slave (
    input  start, data_ref, data_rot,
    output busy, done, found, direction, shift_amt
  );
endinterface

// File: rtl/rotation_decoder.sv
// Sequential inverse of the rotate-by-mux barrel shifter: tries one left-rotate amount per clock
// and reports the rotation that maps data_ref onto data_rot in the shifter's own encoding.
module rotation_decoder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rotation_decoder_if.slave bus
);
  localparam int unsigned AW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_ref;
  logic [WIDTH-1:0] r_rot;
  logic [AW-1:0]    r_k;
  logic             r_busy;
  logic             r_done;
  logic             r_found;
  logic             r_dir;
  logic [AW-1:0]    r_amt;

  logic [2*WIDTH-1:0] w_dbl;
  logic [WIDTH-1:0]   w_rotl;
  logic               w_match;
  logic               w_last;
  logic               w_left;
  logic [AW-1:0]      w_right_amt;

  // Upper half of the doubled word shifted left by k is rotl(ref, k).
  always_comb begin
    w_dbl       = {r_ref, r_ref} << r_k;
    w_rotl      = w_dbl[2*WIDTH-1:WIDTH];
    w_match     = (w_rotl == r_rot);
    w_last      = (r_k == AW'(WIDTH - 1));
    w_left      = (r_k <= AW'(WIDTH / 2));
    w_right_amt = AW'(WIDTH) - r_k;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_ref   <= '0;
      r_rot   <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
      r_dir   <= 1'b0;
      r_amt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle, StDone: begin
          if (bus.start) begin
            r_ref   <= bus.data_ref;
            r_rot   <= bus.data_rot;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= StSearch;
          end else begin
            r_state <= StIdle;
          end
        end
        StSearch: begin
          if (w_match) begin
            r_found <= 1'b1;
            r_dir   <= ~w_left;
            r_amt   <= w_left ? r_k : w_right_amt;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StDone;
          end else if (w_last) begin
            r_found <= 1'b0;
            r_dir   <= 1'b0;
            r_amt   <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StDone;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.found     = r_found;
  assign bus.direction = r_dir;
  assign bus.shift_amt = r_amt;
endmodule
